memory_stage: RTL



---
 rtl/memory_stage_pkg.sv | 36 +++
 rtl/memory_if.sv | 45 ++++
 rtl/mem_access_fsm.sv | 74 +++++++
 rtl/memory_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: datapath words, register indices,
// writeback-source encodings, access-FSM states and the EX/MEM latch layout.
package memory_stage_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [1:0] {
        RSEL_ALU  = 2'd0,
        RSEL_LOAD = 2'd1,
        RSEL_NPC  = 2'd2,
        RSEL_RSVD = 2'd3
    } regsel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memstate_t;

    typedef struct packed {
        word_t    aluout;
        word_t    rtdat;
        word_t    npc;
        logic     dren;
        logic     dwen;
        logic     regwr;
        regsel_t  regsel;
        regbits_t regdst;
        logic     halt;
    } exmem_t;

endpackage

// File: rtl/memory_if.sv
// Bundle of the memory-stage signals; .mem is the stage's view, .tb the driver's.
interface memory_if (
    input logic CLK
);
    logic        ihit;
    logic        flush;
    logic [31:0] ALUOut_next;
    logic [31:0] rtdat;
    logic        dREN_next;
    logic        dWEN_next;
    logic        regWr_next;
    logic [1:0]  regSel_next;
    logic [4:0]  regDst_next;
    logic [31:0] nPC_next;
    logic        halt_next;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic [31:0] wdat;
    logic        regWr_wb;
    logic [4:0]  regDst_wb;
    logic        halt_wb;
    logic [31:0] stall_cycles;

    modport mem (
        input  CLK, ihit, flush, ALUOut_next, rtdat, dREN_next, dWEN_next,
               regWr_next, regSel_next, regDst_next, nPC_next, halt_next,
               dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wdat,
               regWr_wb, regDst_wb, halt_wb, stall_cycles
    );

    modport tb (
        input  CLK, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wdat,
               regWr_wb, regDst_wb, halt_wb, stall_cycles,
        output ihit, flush, ALUOut_next, rtdat, dREN_next, dWEN_next,
               regWr_next, regSel_next, regDst_next, nPC_next, halt_next,
               dhit, dmemload
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Data-cache access controller: one request per memory instruction, held
// until dhit, with the load buffer and the upstream stall.
module mem_access_fsm
    import memory_stage_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              advance,
    input  logic              cap_ren,
    input  logic              cap_wen,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              mem_stall,
    output logic [WORD_W-1:0] loadbuf
);

    memstate_t         state_r;
    logic              ren_r;
    logic              wen_r;
    logic              stall_r;
    logic [WORD_W-1:0] loadbuf_r;

    // State, request/stall flags and load buffer; stall_r mirrors state_r==ACCESS.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            ren_r     <= 1'b0;
            wen_r     <= 1'b0;
            stall_r   <= 1'b0;
            loadbuf_r <= '0;
        end else begin
            case (state_r)
                ACCESS: begin
                    if (dhit) begin
                        state_r   <= DONE;
                        ren_r     <= 1'b0;
                        wen_r     <= 1'b0;
                        stall_r   <= 1'b0;
                        loadbuf_r <= dmemload;
                    end else begin
                        state_r   <= ACCESS;
                    end
                end
                IDLE, DONE: begin
                    if (advance) begin
                        state_r <= (cap_ren | cap_wen) ? ACCESS : IDLE;
                        // a load+store pair is issued as a store only
                        ren_r   <= cap_ren & ~cap_wen;
                        wen_r   <= cap_wen;
                        stall_r <= cap_ren | cap_wen;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ren_r   <= 1'b0;
                    wen_r   <= 1'b0;
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    assign dmemREN   = ren_r;
    assign dmemWEN   = wen_r;
    assign mem_stall = stall_r;
    assign loadbuf   = loadbuf_r;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM latch, data-cache access and MEM/WB next-state.
// Optional stall-cycle counter enabled by defining MEM_STALLCNT_EN.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] ALUOut_next,
    input  logic [WORD_W-1:0] rtdat,
    input  logic              dREN_next,
    input  logic              dWEN_next,
    input  logic              regWr_next,
    input  logic [1:0]        regSel_next,
    input  logic [REG_W-1:0]  regDst_next,
    input  logic [WORD_W-1:0] nPC_next,
    input  logic              halt_next,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] wdat,
    output logic              regWr_wb,
    output logic [REG_W-1:0]  regDst_wb,
    output logic              halt_wb,
    output logic [31:0]       stall_cycles
);

    exmem_t            lat_r;
    logic              halt_wb_r;
    logic              mem_stall_s;
    logic              advance_s;
    logic              cap_ren_s;
    logic              cap_wen_s;
    logic [WORD_W-1:0] loadbuf_s;
    logic [WORD_W-1:0] wdat_s;

    assign advance_s = ihit & ~mem_stall_s & ~halt_wb_r;
    assign cap_ren_s = dREN_next & ~flush;
    assign cap_wen_s = dWEN_next & ~flush;

    // EX/MEM latch; flush only matters on an advancing edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_r <= '0;
        end else if (advance_s) begin
            if (flush) begin
                lat_r <= '0;
            end else begin
                lat_r.aluout <= ALUOut_next;
                lat_r.rtdat  <= rtdat;
                lat_r.npc    <= nPC_next;
                lat_r.dren   <= dREN_next;
                lat_r.dwen   <= dWEN_next;
                lat_r.regwr  <= regWr_next;
                lat_r.regsel <= regsel_t'(regSel_next);
                lat_r.regdst <= regDst_next;
                lat_r.halt   <= halt_next;
            end
        end else begin
            lat_r <= lat_r;
        end
    end

    // Sticky halt, raised once the latched halt is no longer waiting on memory.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_wb_r <= 1'b0;
        end else if (lat_r.halt && !mem_stall_s) begin
            halt_wb_r <= 1'b1;
        end else begin
            halt_wb_r <= halt_wb_r;
        end
    end

    mem_access_fsm #(
        .WORD_W (WORD_W)
    ) u_fsm (
        .CLK       (CLK),
        .nRST      (nRST),
        .advance   (advance_s),
        .cap_ren   (cap_ren_s),
        .cap_wen   (cap_wen_s),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .mem_stall (mem_stall_s),
        .loadbuf   (loadbuf_s)
    );

    // Writeback source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        wdat_s = lat_r.aluout;
        case (lat_r.regsel)
            RSEL_LOAD: wdat_s = loadbuf_s;
            RSEL_NPC:  wdat_s = lat_r.npc;
            default:   wdat_s = lat_r.aluout;
        endcase
    end

`ifdef MEM_STALLCNT_EN
    logic [31:0] stall_cnt_r;

    // Free-running count of stalled cycles, wrapping naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= 32'd0;
        end else if (mem_stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`else
    assign stall_cycles = 32'd0;
`endif

    assign dmemaddr  = lat_r.aluout;
    assign dmemstore = lat_r.rtdat;
    assign mem_stall = mem_stall_s;
    assign wdat      = wdat_s;
    assign regWr_wb  = lat_r.regwr & ~mem_stall_s;
    assign regDst_wb = lat_r.regdst;
    assign halt_wb   = halt_wb_r;

endmodule
